dhcp_vlg_rx: RTL and testbench
==============================

DHCP_VLG_RX -- requirements
Module: dhcp_vlg_rx

Interface
REQ-001 SHALL have parameter VERBOSE, 0, when 1 print one simulation line per accepted or rejected message.
REQ-002 SHALL have parameter DUT_STRING, "", prefix for the VERBOSE prints.
REQ-003 SHALL have port clk input 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst input 1: asynchronous, active-high reset.
REQ-005 SHALL have ports in_dat input 8, in_val input 1, in_sof input 1, in_eof input 1: UDP payload byte stream. A byte is accepted only when in_val=1; in_sof/in_eof qualify the first/last byte.
REQ-006 SHALL have ports out_val output 1, out_err output 1: one-cycle pulses for a good or rejected message.
REQ-007 SHALL have ports dhcp_op output 8, dhcp_xid output 32, dhcp_nxt_cli_addr output 32 (yiaddr), dhcp_srv_ip_addr output 32 (siaddr).
REQ-008 SHALL have ports opt_message_type output 8, opt_subnet_mask output 32, opt_router output 32, opt_lease_time output 32, opt_server_id output 32.
REQ-009 SHALL have ports opt_message_type_pres, opt_subnet_mask_pres, opt_router_pres, opt_lease_time_pres, opt_server_id_pres: each output 1, option seen in the last good message.

Function
REQ-010 SHALL count payload bytes (9-bit index) from the in_sof byte = 0. Capture op at 0, xid at 4-7, yiaddr at 16-19, siaddr at 20-23, all big-endian (first byte is MSB). Check cookie 63 82 53 63 at 236-239.
REQ-011 SHALL use FSM states IDLE, HDR, OPT_CODE, OPT_LEN, OPT_DATA, TAIL, with transitions as follows:
- IDLE→HDR on in_sof.
- HDR→OPT_CODE after byte 239.
- OPT_CODE→OPT_LEN on any code other than 0 or 255. Code 0 stays in OPT_CODE. Code 255 goes to TAIL.
- OPT_LEN→OPT_DATA if len>0, else →OPT_CODE.
- OPT_DATA→OPT_CODE when the data byte counter reaches len.
- TAIL ignores bytes until eof.
REQ-012 SHALL decode options: 1 subnet mask, 3 router (first 4 bytes only), 51 lease time, 53 message type (1 byte), 54 server id. A recognised option is marked present only when all the bytes it needs are received. Unknown codes are skipped by length.
REQ-013 SHALL apply the last occurrence when an option repeats within one message.
REQ-014 SHALL capture into working registers. At a good eof, copy all fields and pres bits to the outputs and pulse out_val on the next cycle (latency 1 clk after the eof byte). Outputs otherwise hold their values.
REQ-015 SHALL pulse out_err instead of out_val, and leave the outputs unchanged, when any of these occurs:
- eof before byte 239;
- cookie mismatch;
- eof in OPT_LEN or OPT_DATA;
- eof in OPT_CODE without a 255 seen;
- in_sof and in_eof on the same byte.
REQ-016 SHALL treat in_sof in any non-IDLE state as abandoning the current message (no pulse) and restarting at byte index 0 with that byte.
REQ-017 SHALL ignore in_eof and data while in IDLE; gaps with in_val=0 stall the FSM with no state change.
REQ-018 SHALL never assert out_val and out_err in the same cycle.
REQ-019 SHALL clear the working pres bits at each in_sof.

Reset
REQ-020 SHALL, while rst=1, drive out_val=0, out_err=0, all field outputs 0, all pres bits 0, FSM=IDLE, counters 0.
REQ-021 SHALL, on rst asserting mid-message, discard the message and produce no pulse after release.
REQ-022 SHALL, after rst releases, ignore bytes until the next in_sof.

Verification
REQ-023 Offer: xid=0xDEADBEEF, op=2, yiaddr=192.168.1.100, siaddr=192.168.1.1, options 53/1/02, 54/4/c0a80101, 1/4/ffffff00, 51/4/00000e10, 255 → out_val 1 clk after eof, fields exact, pres for 53/54/1/51=1, router_pres=0.
REQ-024 Ack with option 3 len 8 (10.0.0.1, 10.0.0.2), pad bytes 0 between options and 20 bytes after 255 → opt_router=0x0A000001, out_val once at eof.
REQ-025 Cookie byte 239=0x64 → out_err pulse, outputs keep the REQ-023 values.
REQ-026 eof on the 2nd byte of option 54 data → out_err; eof at byte 100 → out_err.
REQ-027 in_sof arriving at byte 150 of message A, then a full message B → exactly one out_val carrying B's xid; random in_val gaps give the same result.
REQ-028 rst asserted at byte 245, released, then a complete message → a single out_val with pres bits reflecting only that message.

Source files
------------

// File: rtl/dhcp_vlg_rx.sv
// DHCP reply parser: walks the UDP payload byte stream, captures header fields and a
// handful of options, and publishes them with a one-cycle out_val or out_err pulse.
module dhcp_vlg_rx #(
  parameter int VERBOSE    = 0,
  parameter     DUT_STRING = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_dat,
  input  logic        in_val,
  input  logic        in_sof,
  input  logic        in_eof,
  output logic        out_val,
  output logic        out_err,
  output logic [7:0]  dhcp_op,
  output logic [31:0] dhcp_xid,
  output logic [31:0] dhcp_nxt_cli_addr,
  output logic [31:0] dhcp_srv_ip_addr,
  output logic [7:0]  opt_message_type,
  output logic [31:0] opt_subnet_mask,
  output logic [31:0] opt_router,
  output logic [31:0] opt_lease_time,
  output logic [31:0] opt_server_id,
  output logic        opt_message_type_pres,
  output logic        opt_subnet_mask_pres,
  output logic        opt_router_pres,
  output logic        opt_lease_time_pres,
  output logic        opt_server_id_pres
);

  // state    | meaning
  // IDLE     | waiting for in_sof
  // HDR      | fixed BOOTP header, bytes 0..239 incl. magic cookie
  // OPT_CODE | expecting an option code (0 = pad, 255 = end)
  // OPT_LEN  | expecting the option length byte
  // OPT_DATA | consuming option payload bytes
  // TAIL     | after end option or bad cookie, waiting for in_eof
  typedef enum logic [2:0] {IDLE, HDR, OPT_CODE, OPT_LEN, OPT_DATA, TAIL} state_t;

  state_t      state;
  logic [8:0]  idx;
  logic [7:0]  opt_code;
  logic [7:0]  opt_len;
  logic [7:0]  opt_cnt;
  logic        bad;
  logic [7:0]  w_op;
  logic [31:0] w_xid, w_yi, w_si;
  logic [7:0]  w_mt;
  logic [31:0] w_mask, w_router, w_lease, w_sid;
  // pres bit order: 0 msg type, 1 mask, 2 router, 3 lease, 4 server id
  logic [4:0]  w_pres;

  logic [7:0]  cookie_byte;
  logic        cookie_miss;
  logic        take_good;
  logic        take_err;
  logic        opt_word;

  always_comb begin
    cookie_byte = 8'h63;
    case (idx[1:0])
      2'd1:    cookie_byte = 8'h82;
      2'd2:    cookie_byte = 8'h53;
      default: cookie_byte = 8'h63;
    endcase
    cookie_miss = (idx >= 9'd236) && (in_dat != cookie_byte);
    opt_word    = (opt_cnt < 8'd4);
  end

  always_comb begin
    take_good = 1'b0;
    take_err  = 1'b0;
    if (in_val && in_eof) begin
      if (in_sof) begin
        take_err = 1'b1;
      end else begin
        case (state)
          HDR, OPT_LEN, OPT_DATA: take_err = 1'b1;
          OPT_CODE: begin
            take_good = (in_dat == 8'hFF);
            take_err  = (in_dat != 8'hFF);
          end
          TAIL: begin
            take_good = !bad;
            take_err  = bad;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      idx                   <= '0;
      opt_code              <= '0;
      opt_len               <= '0;
      opt_cnt               <= '0;
      bad                   <= 1'b0;
      w_op                  <= '0;
      w_xid                 <= '0;
      w_yi                  <= '0;
      w_si                  <= '0;
      w_mt                  <= '0;
      w_mask                <= '0;
      w_router              <= '0;
      w_lease               <= '0;
      w_sid                 <= '0;
      w_pres                <= '0;
      out_val               <= 1'b0;
      out_err               <= 1'b0;
      dhcp_op               <= '0;
      dhcp_xid              <= '0;
      dhcp_nxt_cli_addr     <= '0;
      dhcp_srv_ip_addr      <= '0;
      opt_message_type      <= '0;
      opt_subnet_mask       <= '0;
      opt_router            <= '0;
      opt_lease_time        <= '0;
      opt_server_id         <= '0;
      opt_message_type_pres <= 1'b0;
      opt_subnet_mask_pres  <= 1'b0;
      opt_router_pres       <= 1'b0;
      opt_lease_time_pres   <= 1'b0;
      opt_server_id_pres    <= 1'b0;
    end else begin
      out_val <= take_good;
      out_err <= take_err;
      if (take_good) begin
        dhcp_op               <= w_op;
        dhcp_xid              <= w_xid;
        dhcp_nxt_cli_addr     <= w_yi;
        dhcp_srv_ip_addr      <= w_si;
        opt_message_type      <= w_mt;
        opt_subnet_mask       <= w_mask;
        opt_router            <= w_router;
        opt_lease_time        <= w_lease;
        opt_server_id         <= w_sid;
        opt_message_type_pres <= w_pres[0];
        opt_subnet_mask_pres  <= w_pres[1];
        opt_router_pres       <= w_pres[2];
        opt_lease_time_pres   <= w_pres[3];
        opt_server_id_pres    <= w_pres[4];
      end

      if (in_val) begin
        if (in_sof) begin
          // a new sof always wins, abandoning whatever was in flight
          w_pres <= '0;
          bad    <= 1'b0;
          w_op   <= in_dat;
          idx    <= in_eof ? 9'd0 : 9'd1;
          state  <= in_eof ? IDLE : HDR;
        end else if (in_eof && state != IDLE) begin
          state <= IDLE;
          idx   <= '0;
        end else begin
          case (state)
            HDR: begin
              idx <= idx + 9'd1;
              if (idx >= 9'd4 && idx <= 9'd7)   w_xid <= {w_xid[23:0], in_dat};
              if (idx >= 9'd16 && idx <= 9'd19) w_yi  <= {w_yi[23:0], in_dat};
              if (idx >= 9'd20 && idx <= 9'd23) w_si  <= {w_si[23:0], in_dat};
              if (cookie_miss) bad <= 1'b1;
              if (idx == 9'd239) state <= (bad || cookie_miss) ? TAIL : OPT_CODE;
            end
            OPT_CODE: begin
              opt_code <= in_dat;
              if (in_dat == 8'hFF)      state <= TAIL;
              else if (in_dat != 8'h00) state <= OPT_LEN;
            end
            OPT_LEN: begin
              // a repeat restarts that option, so only the last occurrence counts
              case (opt_code)
                8'd53:   w_pres[0] <= 1'b0;
                8'd1:    w_pres[1] <= 1'b0;
                8'd3:    w_pres[2] <= 1'b0;
                8'd51:   w_pres[3] <= 1'b0;
                8'd54:   w_pres[4] <= 1'b0;
                default: ;
              endcase
              opt_len <= in_dat;
              opt_cnt <= '0;
              state   <= (in_dat == 8'h00) ? OPT_CODE : OPT_DATA;
            end
            OPT_DATA: begin
              case (opt_code)
                8'd53: if (opt_cnt == 8'd0) begin
                  w_mt      <= in_dat;
                  w_pres[0] <= 1'b1;
                end
                8'd1: if (opt_word) begin
                  w_mask <= {w_mask[23:0], in_dat};
                  if (opt_cnt == 8'd3) w_pres[1] <= 1'b1;
                end
                8'd3: if (opt_word) begin
                  w_router <= {w_router[23:0], in_dat};
                  if (opt_cnt == 8'd3) w_pres[2] <= 1'b1;
                end
                8'd51: if (opt_word) begin
                  w_lease <= {w_lease[23:0], in_dat};
                  if (opt_cnt == 8'd3) w_pres[3] <= 1'b1;
                end
                8'd54: if (opt_word) begin
                  w_sid <= {w_sid[23:0], in_dat};
                  if (opt_cnt == 8'd3) w_pres[4] <= 1'b1;
                end
                default: ;
              endcase
              opt_cnt <= opt_cnt + 8'd1;
              if (opt_cnt + 8'd1 == opt_len) state <= OPT_CODE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  if (VERBOSE != 0) begin : g_verbose
    always_ff @(posedge clk) begin
      if (out_val) $display("%s dhcp_vlg_rx accepted op=%0d xid=%08h", DUT_STRING, dhcp_op, dhcp_xid);
      if (out_err) $display("%s dhcp_vlg_rx rejected message", DUT_STRING);
    end
  end

endmodule

// File: tb/tb_dhcp_vlg_rx.sv
// Directed bench for dhcp_vlg_rx: stimulus pushes expected pulses into a scoreboard,
// a negedge monitor pops and compares whenever out_val or out_err fires.
module tb_dhcp_vlg_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_dat = '0;
  logic        in_val = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
  logic        out_val, out_err;
  logic [7:0]  dhcp_op, opt_message_type;
  logic [31:0] dhcp_xid, dhcp_nxt_cli_addr, dhcp_srv_ip_addr;
  logic [31:0] opt_subnet_mask, opt_router, opt_lease_time, opt_server_id;
  logic        opt_message_type_pres, opt_subnet_mask_pres, opt_router_pres;
  logic        opt_lease_time_pres, opt_server_id_pres;

  dhcp_vlg_rx dut (
    .clk(clk), .rst(rst), .in_dat(in_dat), .in_val(in_val), .in_sof(in_sof), .in_eof(in_eof),
    .out_val(out_val), .out_err(out_err), .dhcp_op(dhcp_op), .dhcp_xid(dhcp_xid),
    .dhcp_nxt_cli_addr(dhcp_nxt_cli_addr), .dhcp_srv_ip_addr(dhcp_srv_ip_addr),
    .opt_message_type(opt_message_type), .opt_subnet_mask(opt_subnet_mask),
    .opt_router(opt_router), .opt_lease_time(opt_lease_time), .opt_server_id(opt_server_id),
    .opt_message_type_pres(opt_message_type_pres), .opt_subnet_mask_pres(opt_subnet_mask_pres),
    .opt_router_pres(opt_router_pres), .opt_lease_time_pres(opt_lease_time_pres),
    .opt_server_id_pres(opt_server_id_pres)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [7:0]  op;
    logic [31:0] xid, yi, si;
    logic [7:0]  mt;
    logic [31:0] mask, router, lease, sid;
    logic [4:0]  pres;  // {sid, lease, router, mask, mt}
  } exp_t;

  exp_t        sb[$];
  exp_t        last_good;
  logic [7:0]  msg[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_trig = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] pres_now();
    return {opt_server_id_pres, opt_lease_time_pres, opt_router_pres,
            opt_subnet_mask_pres, opt_message_type_pres};
  endfunction

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (out_val || out_err)) begin
        chk("val_err_exclusive", 32'(out_val & out_err), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'(out_val), 32'(out_err));
          chk("unexpected_pulse_cnt", 32'd1, 32'd0 + 32'(sb.size()));
        end else begin
          e = sb.pop_front();
          chk("pulse_kind_err", 32'(out_err), 32'(e.err));
          chk("pulse_latency", 32'(cyc), 32'(last_trig));
          chk("op", 32'(dhcp_op), 32'(e.op));
          chk("xid", dhcp_xid, e.xid);
          chk("yiaddr", dhcp_nxt_cli_addr, e.yi);
          chk("siaddr", dhcp_srv_ip_addr, e.si);
          chk("pres", 32'(pres_now()), 32'(e.pres));
          if (e.pres[0]) chk("msg_type", 32'(opt_message_type), 32'(e.mt));
          if (e.pres[1]) chk("subnet_mask", opt_subnet_mask, e.mask);
          if (e.pres[2]) chk("router", opt_router, e.router);
          if (e.pres[3]) chk("lease_time", opt_lease_time, e.lease);
          if (e.pres[4]) chk("server_id", opt_server_id, e.sid);
        end
      end
    end
  end

  task automatic drive(input logic [7:0] d, input bit s, input bit e);
    in_dat = d; in_val = 1'b1; in_sof = s; in_eof = e;
    @(posedge clk); #1;
    if (e) last_trig = cyc;
    in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic hdr(input logic [7:0] op, input logic [31:0] xid, input logic [31:0] yi,
                     input logic [31:0] si, input logic [7:0] c239);
    msg.delete();
    for (int i = 0; i < 240; i++) msg.push_back(8'h00);
    msg[0] = op; msg[1] = 8'h01; msg[2] = 8'h06;
    for (int i = 0; i < 4; i++) begin
      msg[4 + i]  = xid[31 - 8*i -: 8];
      msg[16 + i] = yi[31 - 8*i -: 8];
      msg[20 + i] = si[31 - 8*i -: 8];
    end
    msg[236] = 8'h63; msg[237] = 8'h82; msg[238] = 8'h53; msg[239] = c239;
  endtask

  task automatic add(input logic [7:0] b);
    msg.push_back(b);
  endtask

  task automatic offer_opts();
    add(8'd53); add(8'd1); add(8'h02);
    add(8'd54); add(8'd4); add(8'hC0); add(8'hA8); add(8'h01); add(8'h01);
    add(8'd1);  add(8'd4); add(8'hFF); add(8'hFF); add(8'hFF); add(8'h00);
    add(8'd51); add(8'd4); add(8'h00); add(8'h00); add(8'h0E); add(8'h10);
    add(8'hFF);
  endtask

  task automatic send(input int n, input bit eof, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      drive(msg[i], i == 0, eof && (i == n - 1));
    end
  endtask

  task automatic push_good(input exp_t e);
    e.err = 1'b0;
    sb.push_back(e);
    last_good = e;
  endtask

  task automatic push_err();
    exp_t e;
    e = last_good;
    e.err = 1'b1;
    sb.push_back(e);
  endtask

  function automatic exp_t mk(input logic [31:0] xid, input logic [31:0] yi, input logic [31:0] si,
                              input logic [7:0] mt, input logic [31:0] mask, input logic [31:0] router,
                              input logic [31:0] lease, input logic [31:0] sid, input logic [4:0] pres);
    exp_t e;
    e.err = 1'b0; e.op = 8'd2; e.xid = xid; e.yi = yi; e.si = si; e.mt = mt;
    e.mask = mask; e.router = router; e.lease = lease; e.sid = sid; e.pres = pres;
    return e;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_out_val"}, 32'(out_val), 32'd0);
    chk({tag, "_out_err"}, 32'(out_err), 32'd0);
    chk({tag, "_op"}, 32'(dhcp_op), 32'd0);
    chk({tag, "_xid"}, dhcp_xid, 32'd0);
    chk({tag, "_yi_si"}, dhcp_nxt_cli_addr | dhcp_srv_ip_addr, 32'd0);
    chk({tag, "_opts"}, 32'(opt_message_type) | opt_subnet_mask | opt_router | opt_lease_time
                         | opt_server_id, 32'd0);
    chk({tag, "_pres"}, 32'(pres_now()), 32'd0);
  endtask

  initial begin
    exp_t offer, ack, minimal;
    last_good = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b0);
    last_good.op = 8'd0;
    offer   = mk(32'hDEADBEEF, 32'hC0A80164, 32'hC0A80101, 8'h02, 32'hFFFFFF00, 32'h0,
                 32'h00000E10, 32'hC0A80101, 5'b11011);
    ack     = mk(32'h12345678, 32'h0A000064, 32'h0A0000FE, 8'h05, 32'h0, 32'h0A000001,
                 32'h0, 32'h0A0000FE, 5'b10101);
    minimal = mk(32'h11223344, 32'h0, 32'h0, 8'h03, 32'h0, 32'h0, 32'h0, 32'h0, 5'b00001);

    // reset state
    idle(2);
    @(negedge clk); chk_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    idle(3);

    // offer
    hdr(8'd2, 32'hDEADBEEF, 32'hC0A80164, 32'hC0A80101, 8'h63); offer_opts();
    push_good(offer); send(msg.size(), 1, 0); idle(4);

    // bad cookie, outputs keep offer values
    hdr(8'd2, 32'hDEADBEEF, 32'hC0A80164, 32'hC0A80101, 8'h64); offer_opts();
    push_err(); send(msg.size(), 1, 0); idle(4);

    // ack: router len 8, pads, 20 trailing bytes after end
    hdr(8'd2, 32'h12345678, 32'h0A000064, 32'h0A0000FE, 8'h63);
    add(8'd53); add(8'd1); add(8'h05); add(8'h00); add(8'h00);
    add(8'd3); add(8'd8);
    add(8'h0A); add(8'h00); add(8'h00); add(8'h01); add(8'h0A); add(8'h00); add(8'h00); add(8'h02);
    add(8'h00);
    add(8'd54); add(8'd4); add(8'h0A); add(8'h00); add(8'h00); add(8'hFE);
    add(8'hFF);
    for (int i = 0; i < 20; i++) add(8'h00);
    push_good(ack); send(msg.size(), 1, 0); idle(4);

    // eof on 2nd byte of option 54 data
    hdr(8'd2, 32'hAAAA0001, 32'h1, 32'h2, 8'h63); offer_opts();
    push_err(); send(240 + 3 + 4, 1, 0); idle(4);

    // eof at byte 100
    push_err(); send(101, 1, 0); idle(4);

    // abandon A at byte 150, then B, without and with gaps
    for (int g = 0; g < 2; g++) begin
      hdr(8'd2, 32'hA0A0A0A0, 32'h1, 32'h2, 8'h63); offer_opts();
      send(150, 0, g == 1);
      hdr(8'd2, 32'hB0B0B0B0, 32'hC0A80164, 32'hC0A80101, 8'h63); offer_opts();
      offer.xid = 32'hB0B0B0B0;
      push_good(offer); send(msg.size(), 1, g == 1); idle(4);
    end

    // sof and eof on one byte
    push_err(); drive(8'h02, 1, 1); idle(4);

    // only option 53: pres bits from earlier messages must not leak
    hdr(8'd2, 32'h11223344, 32'h0, 32'h0, 8'h63);
    add(8'd53); add(8'd1); add(8'h03); add(8'hFF);
    push_good(minimal); send(msg.size(), 1, 0); idle(4);

    // reset at byte 245
    hdr(8'd2, 32'hDEADBEEF, 32'hC0A80164, 32'hC0A80101, 8'h63); offer_opts();
    send(245, 0, 0);
    rst = 1'b1;
    @(negedge clk); chk_zero("midreset");
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) drive(8'hFF, 0, i == 4);
    idle(3);
    hdr(8'd2, 32'h55667788, 32'h0, 32'h0, 8'h63);
    add(8'd53); add(8'd1); add(8'h03); add(8'hFF);
    minimal.xid = 32'h55667788;
    push_good(minimal); send(msg.size(), 1, 0);

    idle(20);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
